// File: rtl/alu_pkg.sv
// Shared types and constants for the round-robin ALU arbiter and its ALU.
// Op encoding, arbiter state encoding and statistics counter width live here.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_OR  = 3'b010,
        ALU_AND = 3'b011,
        ALU_SLL = 3'b100,
        ALU_SRL = 3'b101,
        ALU_NOR = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational n-bit ALU: ADD/SUB/OR/AND/SLL/SRL/NOR and unsigned SLT.
// Shifts use the whole B operand, so any amount of n or more gives zero.
module alu
    import alu_pkg::*;
#(
    parameter int n = 32
) (
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [2:0]   S,
    output logic [n-1:0] Y
);

    localparam logic [n-1:0] SHIFT_LIM = n'(n);

    logic shift_big;

    assign shift_big = (B >= SHIFT_LIM);

    always_comb begin
        Y = '0;
        case (S)
            ALU_ADD: Y = A + B;
            ALU_SUB: Y = A - B;
            ALU_OR:  Y = A | B;
            ALU_AND: Y = A & B;
            ALU_SLL: Y = shift_big ? '0 : (A << B);
            ALU_SRL: Y = shift_big ? '0 : (A >> B);
            ALU_NOR: Y = ~(A | B);
            ALU_SLT: Y = {{(n-1){1'b0}}, (A < B)};
            default: Y = '0;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Purely combinational; any flags that at least one request is present.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  grant,
    output logic            any
);

    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NREQ]) begin
                any   = 1'b1;
                grant = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters, with a one-deep
// registered result. Optional per-requester grant counters: ALU_ARB_STATS_EN.
//
//   state | meaning
//   EMPTY | result register empty, resp_valid=0
//   FULL  | result register holds an unconsumed result, resp_valid=1
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int n    = 32,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*n-1:0] req_a,
    input  logic [NREQ*n-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [n-1:0]      resp_data,
    output logic [IDW-1:0]    resp_id
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic                   clr_stats,
    output logic [NREQ*STAT_W-1:0] grant_cnt
`endif
);

    arb_state_t     state;
    arb_state_t     state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic           any_req;
    logic           can_accept;
    logic           accept;
    logic [n-1:0]   sel_a;
    logic [n-1:0]   sel_b;
    logic [2:0]     sel_op;
    logic [n-1:0]   alu_y;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .any   (any_req)
    );

    // Operands are taken straight from the granted requester; nothing is latched before grant.
    always_comb begin
        sel_a  = req_a[int'(grant)*n +: n];
        sel_b  = req_b[int'(grant)*n +: n];
        sel_op = req_op[int'(grant)*3 +: 3];
    end

    alu #(.n(n)) u_alu (
        .A (sel_a),
        .B (sel_b),
        .S (sel_op),
        .Y (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (resp_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // A full register can still accept when the consumer drains it in the same cycle.
    always_comb begin
        resp_valid = (state == FULL);
        can_accept = (state == EMPTY) || resp_ready;
        accept     = can_accept && any_req;
        req_ready  = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data <= '0;
            resp_id   <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            resp_data <= alu_y;
            resp_id   <= grant;
            if (int'(grant) == NREQ - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant + IDW'(1);
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [STAT_W-1:0] cnt [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_stats
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt[i] <= '0;
            end else if (clr_stats) begin
                cnt[i] <= '0;
            end else if (accept && (int'(grant) == i)) begin
                cnt[i] <= sat_inc(cnt[i]);
            end
        end
        assign grant_cnt[i*STAT_W +: STAT_W] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a result scoreboard.
// Covers reset, round-robin order, backpressure, op corners, async reset and stats.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N  = 32;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*N-1:0]   req_a = '0;
    logic [NR*N-1:0]   req_b = '0;
    logic [NR*3-1:0]   req_op = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [N-1:0]      resp_data;
    logic [1:0]        resp_id;
`ifdef ALU_ARB_STATS_EN
    logic              clr_stats = 1'b0;
    logic [NR*16-1:0]  grant_cnt;
`endif

    alu_arbiter #(.n(N), .NREQ(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
`ifdef ALU_ARB_STATS_EN
        ,
        .clr_stats  (clr_stats),
        .grant_cnt  (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a | b;
            3'd3: return a & b;
            3'd4: return (b >= 32) ? 32'd0 : (a << b[4:0]);
            3'd5: return (b >= 32) ? 32'd0 : (a >> b[4:0]);
            3'd6: return ~(a | b);
            default: return (a < b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]       = 1'b1;
        req_op[i*3 +: 3]   = op;
        req_a[i*N +: N]    = a;
        req_b[i*N +: N]    = b;
    endtask

    task automatic clr_all();
        req_valid = '0;
    endtask

    task automatic do_reset();
        clr_all();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One cycle: check req_ready mid-cycle, push expected result on accept,
    // then after the edge pop and compare the registered response.
    task automatic tick(input string tag, input logic [NR-1:0] exp_ready);
        exp_t e;
        exp_t got;
        int   id;
        @(negedge clk);
        chk($sformatf("%s.ready", tag), req_ready, exp_ready);
        if (exp_ready != '0) begin
            id = 0;
            for (int k = 0; k < NR; k++) if (exp_ready[k]) id = k;
            e.id   = 2'(id);
            e.data = model(req_op[id*3 +: 3], req_a[id*N +: N], req_b[id*N +: N]);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (exp_ready != '0) begin
            if (sb.size() == 0) begin
                chk($sformatf("%s.sb_underflow", tag), 64'd0, 64'd1);
            end else begin
                got = sb.pop_front();
                chk($sformatf("%s.valid", tag), resp_valid, 1'b1);
                chk($sformatf("%s.id", tag), resp_id, got.id);
                chk($sformatf("%s.data", tag), resp_data, got.data);
            end
        end
    endtask

    task automatic corner(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv);
        set_req(2, op, a, b);
        tick(tag, 4'b0100);
        chk($sformatf("%s.const", tag), resp_data, expv);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst.valid", resp_valid, 1'b0);
        chk("rst.data", resp_data, 32'd0);
        chk("rst.id", resp_id, 2'd0);
        chk("rst.ready", req_ready, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single request
        resp_ready = 1'b1;
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        tick("single", 4'b0001);
        chk("single.const", resp_data, 32'd12);
        clr_all();
        tick("single.idle", 4'b0000);
        chk("single.drain", resp_valid, 1'b0);

        // all four valid, round-robin without bubbles
        do_reset();
        resp_ready = 1'b1;
        set_req(0, ALU_ADD, 32'd10, 32'd20);
        set_req(1, ALU_SUB, 32'd100, 32'd1);
        set_req(2, ALU_OR,  32'h0000_00F0, 32'h0000_000F);
        set_req(3, ALU_AND, 32'h0000_FF00, 32'h0000_0FF0);
        tick("rr0", 4'b0001);
        tick("rr1", 4'b0010);
        tick("rr2", 4'b0100);
        tick("rr3", 4'b1000);
        tick("rr4", 4'b0001);
        clr_all();
        tick("rr.idle", 4'b0000);

        // backpressure
        do_reset();
        resp_ready = 1'b1;
        set_req(0, ALU_SUB, 32'd3, 32'd5);
        set_req(1, ALU_ADD, 32'd1, 32'd1);
        tick("bp.first", 4'b0001);
        chk("bp.const", resp_data, 32'hFFFF_FFFE);
        resp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp.hold%0d.ready", c), req_ready, 4'b0000);
            chk($sformatf("bp.hold%0d.valid", c), resp_valid, 1'b1);
            chk($sformatf("bp.hold%0d.data", c), resp_data, 32'hFFFF_FFFE);
            chk($sformatf("bp.hold%0d.id", c), resp_id, 2'd0);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        tick("bp.resume", 4'b0010);
        clr_all();
        tick("bp.idle", 4'b0000);

        // op corners, req2 only
        do_reset();
        resp_ready = 1'b1;
        corner("sll32", ALU_SLL, 32'd1, 32'd32, 32'd0);
        corner("srl31", ALU_SRL, 32'h8000_0000, 32'd31, 32'd1);
        corner("slt_u", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0);
        corner("nor00", ALU_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF);
        corner("sll4", ALU_SLL, 32'h0000_0003, 32'd4, 32'h0000_0030);
        corner("slt_t", ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd1);
        clr_all();
        tick("corner.idle", 4'b0000);

        // asynchronous reset while FULL
        do_reset();
        resp_ready = 1'b0;
        set_req(2, ALU_ADD, 32'd1, 32'd2);
        tick("mid.fill", 4'b0100);
        clr_all();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid.valid", resp_valid, 1'b0);
        chk("mid.data", resp_data, 32'd0);
        chk("mid.ready", req_ready, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        set_req(1, ALU_ADD, 32'd9, 32'd9);
        set_req(3, ALU_ADD, 32'd8, 32'd8);
        tick("post.ptr0", 4'b0010);
        clr_all();
        set_req(2, ALU_ADD, 32'd40, 32'd2);
        tick("post.req2", 4'b0100);
        clr_all();
        tick("post.idle", 4'b0000);

`ifdef ALU_ARB_STATS_EN
        do_reset();
        resp_ready = 1'b1;
        set_req(1, ALU_ADD, 32'd1, 32'd2);
        tick("st.g1a", 4'b0010);
        tick("st.g1b", 4'b0010);
        tick("st.g1c", 4'b0010);
        clr_all();
        set_req(3, ALU_OR, 32'd1, 32'd2);
        tick("st.g3", 4'b1000);
        clr_all();
        chk("st.cnt0", grant_cnt[0*16 +: 16], 16'd0);
        chk("st.cnt1", grant_cnt[1*16 +: 16], 16'd3);
        chk("st.cnt2", grant_cnt[2*16 +: 16], 16'd0);
        chk("st.cnt3", grant_cnt[3*16 +: 16], 16'd1);
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        chk("st.clr", grant_cnt, 64'd0);
`endif

        chk("sb.empty", sb.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
